snoop_responder: RTL and testbench

- Cache-side end of the bus coherence protocol, instantiated once per L1 dcache, next to the cache's CPU-side FSM.
- Services snoops broadcast by the bus coherence controller. Looks up the snooped block in the local 2-way frame array.
- On a Modified hit, drives ownership (cctrans) and streams both block words out for forwarding/writeback. Applies MSI downgrades (M->S, M->I, S->I).

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/snoop_responder.sv | 147 ++++++++++++++
 tb/tb_snoop_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the L1 dcache and its coherence logic.
//   word_t        32-bit data/address word
//   snp_state_t   snoop responder FSM states
//   dcachef_t     dcache address fields {tag, idx, blkoff, bytoff}
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int DTAG_W = 26;
   localparam int DIDX_W = 3;
   localparam int DBLK_W = 1;
   localparam int DBYT_W = 2;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic [DTAG_W-1:0] tag;
      logic [DIDX_W-1:0] idx;
      logic [DBLK_W-1:0] blkoff;
      logic [DBYT_W-1:0] bytoff;
   } dcachef_t;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, XFER0, GAP, XFER1, UPD, DONE
   } snp_state_t;

endpackage

// File: rtl/snoop_responder.sv
// snoop_responder: cache-side end of the bus coherence protocol (MSI).
// Looks up a snooped block in the local 2-way frame array, supplies both
// words of a Modified block (cctrans/dWEN/daddr/dstore) and applies the
// downgrade through a one-cycle state-write strobe (upd_*).
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   ccwait, ccsnoopaddr        snoop request and snooped word address
//   ccwrite, ccinv             BusRdX / invalidate-only qualifiers
//   dwait                      bus not ready for the current word
//   cctrans, dWEN, daddr,
//   dstore                     dirty-block supply to the bus
//   snp_stall                  blocks the CPU-side FSM from the frame array
//   snp_idx, snp_way, snp_word frame-array read address
//   frm_valid/dirty/tag/data   frame-array read data
//   upd_en, upd_valid,
//   upd_dirty                  frame-array state write for (snp_idx, snp_way)
module snoop_responder
   import cpu_types_pkg::*;
#(
   parameter int NSETS = 8,
   parameter int TAG_W = 26,
   parameter int IDX_W = $clog2(NSETS)
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               ccwait,
   input  logic [31:0]        ccsnoopaddr,
   input  logic               ccwrite,
   input  logic               ccinv,
   input  logic               dwait,
   output logic               cctrans,
   output logic               dWEN,
   output logic [31:0]        daddr,
   output logic [31:0]        dstore,
   output logic               snp_stall,
   output logic [IDX_W-1:0]   snp_idx,
   input  logic [1:0]         frm_valid,
   input  logic [1:0]         frm_dirty,
   input  logic [2*TAG_W-1:0] frm_tag,
   output logic               snp_way,
   output logic               snp_word,
   input  logic [31:0]        frm_data,
   output logic               upd_en,
   output logic               upd_valid,
   output logic               upd_dirty
);

   snp_state_t       state, nxt;
   logic [TAG_W-1:0] tag_q;
   logic [IDX_W-1:0] idx_q;
   logic             wr_q, inv_q, way_q;
   logic [1:0]       hit;
   logic             hit_way, hit_dirty;
   word_t            blk_base;
   logic             unused_boff;

   // byte/block offset of the snooped address never matters: whole block moves
   assign unused_boff = ^ccsnoopaddr[2:0];

   assign hit[0]    = frm_valid[0] & (frm_tag[TAG_W-1:0] == tag_q);
   assign hit[1]    = frm_valid[1] & (frm_tag[2*TAG_W-1:TAG_W] == tag_q);
   // way 0 wins a double hit; only meaningful when |hit
   assign hit_way   = ~hit[0];
   assign hit_dirty = frm_dirty[hit_way];
   assign blk_base  = {tag_q, idx_q, 3'b000};

   assign snp_idx   = idx_q;
   assign snp_way   = way_q;
   // combinational so the CPU side is blocked in the very cycle ccwait rises
   assign snp_stall = (state != IDLE) | ccwait;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         tag_q <= '0;
         idx_q <= '0;
         wr_q  <= 1'b0;
         inv_q <= 1'b0;
         way_q <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && ccwait) begin
            tag_q <= ccsnoopaddr[31 -: TAG_W];
            idx_q <= ccsnoopaddr[3 +: IDX_W];
            wr_q  <= ccwrite;
            inv_q <= ccinv;
         end
         if (state == LOOKUP) way_q <= hit_way;
      end
   end

   always_comb begin
      nxt       = state;
      cctrans   = 1'b0;
      dWEN      = 1'b0;
      daddr     = '0;
      dstore    = '0;
      snp_word  = 1'b0;
      upd_en    = 1'b0;
      upd_valid = 1'b0;
      upd_dirty = 1'b0;
      case (state)
         IDLE:
            if (ccwait) nxt = LOOKUP;
         LOOKUP:
            if (!ccwait) nxt = IDLE;
            else if ((|hit) && hit_dirty) begin
               cctrans = 1'b1;
               nxt     = XFER0;
            end
            else if ((|hit) && (wr_q || inv_q)) nxt = UPD;
            else nxt = DONE;
         XFER0: begin
            cctrans = 1'b1;
            dWEN    = 1'b1;
            daddr   = blk_base;
            dstore  = frm_data;
            if (!dwait) nxt = GAP;
         end
         GAP: begin
            // idle beat so the bus can step to the second word
            cctrans = 1'b1;
            nxt     = XFER1;
         end
         XFER1: begin
            cctrans  = 1'b1;
            dWEN     = 1'b1;
            snp_word = 1'b1;
            daddr    = blk_base | 32'h4;
            dstore   = frm_data;
            if (!dwait) nxt = UPD;
         end
         UPD: begin
            // clean hits only reach here on BusRdX/inv, so both paths share
            // one rule: keep the line (as S) only for a plain BusRd
            upd_en    = 1'b1;
            upd_valid = ~(wr_q | inv_q);
            nxt       = DONE;
         end
         DONE:
            if (!ccwait) nxt = IDLE;
         default:
            nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_snoop_responder.sv
module tb_snoop_responder;

   logic        CLK = 1'b0;
   logic        nRST, ccwait, ccwrite, ccinv, dwait;
   logic [31:0] ccsnoopaddr;
   logic        cctrans, dWEN, snp_stall, snp_way, snp_word;
   logic [31:0] daddr, dstore, frm_data;
   logic [2:0]  snp_idx;
   logic [1:0]  frm_valid, frm_dirty;
   logic [51:0] frm_tag;
   logic        upd_en, upd_valid, upd_dirty;

   // frame-array model
   logic        fv [8][2];
   logic        fdy[8][2];
   logic [25:0] ft [8][2];
   logic [31:0] fd [8][2][2];

   int checks = 0;
   int errors = 0;

   // bus-side monitor (monotonic counters; tests take deltas)
   int          nw = 0, dwen_cyc = 0, cct_cyc = 0, n_upd = 0;
   logic [31:0] waddr [16];
   logic [31:0] wdata [16];
   logic        last_uv, last_ud, last_way;
   logic [2:0]  last_idx;

   always #5 CLK = ~CLK;

   assign frm_valid = {fv[snp_idx][1], fv[snp_idx][0]};
   assign frm_dirty = {fdy[snp_idx][1], fdy[snp_idx][0]};
   assign frm_tag   = {ft[snp_idx][1], ft[snp_idx][0]};
   assign frm_data  = fd[snp_idx][snp_way][snp_word];

   snoop_responder dut (
      .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr),
      .ccwrite(ccwrite), .ccinv(ccinv), .dwait(dwait), .cctrans(cctrans),
      .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .snp_stall(snp_stall),
      .snp_idx(snp_idx), .frm_valid(frm_valid), .frm_dirty(frm_dirty),
      .frm_tag(frm_tag), .snp_way(snp_way), .snp_word(snp_word),
      .frm_data(frm_data), .upd_en(upd_en), .upd_valid(upd_valid),
      .upd_dirty(upd_dirty)
   );

   always @(posedge CLK) begin
      if (dWEN) dwen_cyc <= dwen_cyc + 1;
      if (cctrans) cct_cyc <= cct_cyc + 1;
      if (dWEN && !dwait) begin
         waddr[nw[3:0]] <= daddr;
         wdata[nw[3:0]] <= dstore;
         nw <= nw + 1;
      end
      if (upd_en) begin
         n_upd    <= n_upd + 1;
         last_uv  <= upd_valid;
         last_ud  <= upd_dirty;
         last_way <= snp_way;
         last_idx <= snp_idx;
      end
   end

   task automatic init_frames();
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 2; w++) begin
            fv[s][w] = 1'b0; fdy[s][w] = 1'b0; ft[s][w] = '0;
            fd[s][w][0] = 32'h0; fd[s][w][1] = 32'h0;
         end
      // set 3: way 0 clean other tag, way 1 M with tag 0x1234
      fv[3][0] = 1'b1; ft[3][0] = 26'h1235; fd[3][0][0] = 32'h1111_1111; fd[3][0][1] = 32'h2222_2222;
      fv[3][1] = 1'b1; fdy[3][1] = 1'b1; ft[3][1] = 26'h1234;
      fd[3][1][0] = 32'hAAAA_0001; fd[3][1][1] = 32'hBBBB_0002;
      // set 0: way 0 other tag, way 1 invalid but matching tag 1
      fv[0][0] = 1'b1; ft[0][0] = 26'h2; ft[0][1] = 26'h1;
      // set 5: S lines, way 0 tag 0x55, way 1 tag 0x56
      fv[5][0] = 1'b1; ft[5][0] = 26'h55;
      fv[5][1] = 1'b1; ft[5][1] = 26'h56;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({cctrans, dWEN, upd_en, upd_valid, upd_dirty, snp_stall, snp_way, snp_word} !== 8'h0) begin
         errors++; $display("FAIL reset_ctl got %b want 00000000",
            {cctrans, dWEN, upd_en, upd_valid, upd_dirty, snp_stall, snp_way, snp_word});
      end
      checks++;
      if ({daddr, dstore, snp_idx} !== 67'h0) begin
         errors++; $display("FAIL reset_data daddr %h dstore %h idx %0d want 0", daddr, dstore, snp_idx);
      end
      @(negedge CLK); nRST = 1'b1;
   endtask

   task automatic test_miss();
      int su = n_upd, sd = dwen_cyc, sc = cct_cyc;
      @(negedge CLK); ccsnoopaddr = 32'h0000_0040; ccwrite = 1'b0; ccinv = 1'b0; dwait = 1'b0; ccwait = 1'b1;
      #1;
      checks++;
      if (snp_stall !== 1'b1) begin errors++; $display("FAIL miss_stall_same_cycle got %b want 1", snp_stall); end
      repeat (5) @(negedge CLK);
      #1;
      checks++;
      if (snp_stall !== 1'b1) begin errors++; $display("FAIL miss_stall_held got %b want 1", snp_stall); end
      ccwait = 1'b0;
      @(negedge CLK); #1;
      checks++;
      if (snp_stall !== 1'b0) begin errors++; $display("FAIL miss_stall_release got %b want 0", snp_stall); end
      checks++;
      if ({n_upd - su, dwen_cyc - sd, cct_cyc - sc} !== {32'd0, 32'd0, 32'd0}) begin
         errors++; $display("FAIL miss_activity upd %0d dwen %0d cct %0d want 0 0 0", n_upd - su, dwen_cyc - sd, cct_cyc - sc);
      end
   endtask

   task automatic test_busrd_m();
      int su = n_upd, sw = nw, sd = dwen_cyc, sc = cct_cyc;
      @(negedge CLK); ccsnoopaddr = 32'h0004_8D1C; ccwrite = 1'b0; ccinv = 1'b0; dwait = 1'b0; ccwait = 1'b1;
      repeat (8) @(negedge CLK);
      ccwait = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      checks++;
      if (nw - sw !== 2) begin errors++; $display("FAIL busrd_words got %0d want 2", nw - sw); end
      checks++;
      if (waddr[sw % 16] !== 32'h0004_8D18 || wdata[sw % 16] !== 32'hAAAA_0001) begin
         errors++; $display("FAIL busrd_w0 got %h/%h want 00048d18/aaaa0001", waddr[sw % 16], wdata[sw % 16]);
      end
      checks++;
      if (waddr[(sw + 1) % 16] !== 32'h0004_8D1C || wdata[(sw + 1) % 16] !== 32'hBBBB_0002) begin
         errors++; $display("FAIL busrd_w1 got %h/%h want 00048d1c/bbbb0002", waddr[(sw + 1) % 16], wdata[(sw + 1) % 16]);
      end
      checks++;
      if (dwen_cyc - sd !== 2 || cct_cyc - sc !== 4) begin
         errors++; $display("FAIL busrd_timing dwen %0d cct %0d want 2 4", dwen_cyc - sd, cct_cyc - sc);
      end
      checks++;
      if (n_upd - su !== 1 || {last_uv, last_ud, last_way, last_idx} !== 6'b101_011) begin
         errors++; $display("FAIL busrd_upd n %0d v%b d%b way%b idx%0d want 1 v1 d0 way1 idx3",
            n_upd - su, last_uv, last_ud, last_way, last_idx);
      end
   endtask

   task automatic test_busrdx_wait();
      int su = n_upd, sw = nw, sd = dwen_cyc, sc = cct_cyc;
      int hold = 0;
      @(negedge CLK); ccsnoopaddr = 32'h0004_8D18; ccwrite = 1'b1; ccinv = 1'b0; dwait = 1'b1; ccwait = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK); #1;
         if (dWEN) begin
            if (hold < 3) begin dwait = 1'b1; hold++; end
            else begin dwait = 1'b0; hold = 0; end
         end else dwait = 1'b1;
      end
      ccwait = 1'b0; dwait = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      checks++;
      if (nw - sw !== 2 || wdata[sw % 16] !== 32'hAAAA_0001 || waddr[(sw + 1) % 16] !== 32'h0004_8D1C ||
          wdata[(sw + 1) % 16] !== 32'hBBBB_0002) begin
         errors++; $display("FAIL busrdx_words n %0d w0 %h w1 %h/%h want 2 aaaa0001 00048d1c/bbbb0002",
            nw - sw, wdata[sw % 16], waddr[(sw + 1) % 16], wdata[(sw + 1) % 16]);
      end
      checks++;
      if (dwen_cyc - sd !== 8 || cct_cyc - sc !== 10) begin
         errors++; $display("FAIL busrdx_hold dwen %0d cct %0d want 8 10", dwen_cyc - sd, cct_cyc - sc);
      end
      checks++;
      if (n_upd - su !== 1 || {last_uv, last_ud, last_way} !== 3'b001) begin
         errors++; $display("FAIL busrdx_upd n %0d v%b d%b way%b want 1 v0 d0 way1", n_upd - su, last_uv, last_ud, last_way);
      end
   endtask

   task automatic test_inv_clean();
      int su = n_upd, sc = cct_cyc;
      @(negedge CLK); ccsnoopaddr = 32'h0000_1568; ccwrite = 1'b0; ccinv = 1'b1; dwait = 1'b0; ccwait = 1'b1;
      @(negedge CLK); #1;
      checks++;
      if (upd_en !== 1'b0 || cctrans !== 1'b0) begin
         errors++; $display("FAIL inv_lookup upd_en %b cctrans %b want 0 0", upd_en, cctrans);
      end
      @(negedge CLK); #1;
      checks++;
      if ({upd_en, upd_valid, upd_dirty, snp_way, snp_idx} !== 7'b1000_101) begin
         errors++; $display("FAIL inv_upd en%b v%b d%b way%b idx%0d want en1 v0 d0 way0 idx5",
            upd_en, upd_valid, upd_dirty, snp_way, snp_idx);
      end
      repeat (3) @(negedge CLK);
      ccwait = 1'b0; ccinv = 1'b0;
      @(negedge CLK); #1;
      checks++;
      if (n_upd - su !== 1 || cct_cyc - sc !== 0) begin
         errors++; $display("FAIL inv_totals upd %0d cct %0d want 1 0", n_upd - su, cct_cyc - sc);
      end
   endtask

   task automatic test_held_ccwait();
      int su = n_upd, sw = nw;
      @(negedge CLK); ccsnoopaddr = 32'h0004_8D18; ccwrite = 1'b0; ccinv = 1'b0; dwait = 1'b0; ccwait = 1'b1;
      // 6 cycles to reach DONE, then 5 more with ccwait still high
      repeat (11) @(negedge CLK);
      #1;
      checks++;
      if (snp_stall !== 1'b1 || cctrans !== 1'b0) begin
         errors++; $display("FAIL held_done stall %b cctrans %b want 1 0", snp_stall, cctrans);
      end
      ccwait = 1'b0;
      @(negedge CLK); #1;
      checks++;
      if (n_upd - su !== 1 || nw - sw !== 2) begin
         errors++; $display("FAIL held_single upd %0d words %0d want 1 2", n_upd - su, nw - sw);
      end
   endtask

   task automatic test_reset_mid();
      int su, sw;
      bit found = 1'b0;
      @(negedge CLK); ccsnoopaddr = 32'h0004_8D18; ccwrite = 1'b1; ccinv = 1'b0; dwait = 1'b0; ccwait = 1'b1;
      su = n_upd;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK); #1;
         if (dWEN && snp_word) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rst_reach_xfer1 got timeout want XFER1 within 20 cycles"); end
      nRST = 1'b0; ccwait = 1'b0;
      #1;
      checks++;
      if ({cctrans, dWEN, upd_en, upd_valid, snp_stall, snp_word, snp_way} !== 7'h0 || {daddr, dstore} !== 64'h0) begin
         errors++; $display("FAIL rst_mid_outputs ctl %b daddr %h dstore %h want 0",
            {cctrans, dWEN, upd_en, upd_valid, snp_stall, snp_word, snp_way}, daddr, dstore);
      end
      @(negedge CLK); #1;
      checks++;
      if (n_upd - su !== 0) begin errors++; $display("FAIL rst_mid_no_upd got %0d want 0", n_upd - su); end
      nRST = 1'b1;
      su = n_upd; sw = nw;
      @(negedge CLK); ccwait = 1'b1;
      repeat (8) @(negedge CLK);
      ccwait = 1'b0; ccwrite = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      checks++;
      if (nw - sw !== 2 || wdata[(sw + 1) % 16] !== 32'hBBBB_0002 || n_upd - su !== 1 || last_uv !== 1'b0) begin
         errors++; $display("FAIL rst_recover words %0d w1 %h upd %0d v%b want 2 bbbb0002 1 v0",
            nw - sw, wdata[(sw + 1) % 16], n_upd - su, last_uv);
      end
   endtask

   initial begin
      nRST = 1'b0; ccwait = 1'b0; ccwrite = 1'b0; ccinv = 1'b0; dwait = 1'b0; ccsnoopaddr = '0;
      init_frames();
      #2;
      test_reset();
      test_miss();
      test_busrd_m();
      test_busrdx_wait();
      test_inv_clean();
      test_held_ccwait();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
